// File: rtl/hw_sorter.sv
// -----------------------------------------------------------------------------
// hw_sorter
//   Self-contained N-entry ascending sorter (unsigned words).
//   Reset loads a fixed pseudo-random pattern into the internal array.
//   With ena high the block runs N passes of odd-even transposition sort.
//   It then presents the sorted array one word per enabled cycle.
//
// Ports
//   clk       in   1      rising-edge clock
//   rst       in   1      asynchronous, active-low reset
//   ena       in   1      run enable; 0 pauses the block where it is
//   dout      out  W      mem[out_cnt], a combinational read of the array
//   out_cnt   out  CNT_W  index of the word currently on dout
//   started   out  1      set when word 0 of the sorted stream appears
//   finished  out  1      set once all N words have been presented
// -----------------------------------------------------------------------------
module hw_sorter #(
    parameter int N     = 128,
    parameter int W     = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    output logic [W-1:0]     dout,
    output logic [CNT_W-1:0] out_cnt,
    output logic             started,
    output logic             finished
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SORT   = 2'd1;
    localparam logic [1:0] S_OUTPUT = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam int              IDX_W = $clog2(N);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    // Golden-ratio multiplicative hash gives a well-scrambled reset pattern.
    function automatic logic [W-1:0] seed_word(input int i);
        logic [31:0] p;
        p = 32'(i) * 32'h9E37_79B1;
        return W'(p);
    endfunction

    logic [1:0]       state_q,    state_d;
    logic [CNT_W-1:0] pass_q,     pass_d;
    logic [CNT_W-1:0] out_cnt_q,  out_cnt_d;
    logic             started_q,  started_d;
    logic             finished_q, finished_d;
    logic [W-1:0]     mem_q [N];
    logic [W-1:0]     mem_d [N];

    always_comb begin
        // NOTE: every signal gets a default first, so no path leaves a value
        // unassigned and no latch can be inferred.
        state_d    = state_q;
        pass_d     = pass_q;
        out_cnt_d  = out_cnt_q;
        started_d  = started_q;
        finished_d = finished_q;
        mem_d      = mem_q;

        if (ena) begin
            case (state_q)
                S_IDLE: begin
                    // The edge that leaves IDLE only arms the sorter.
                    // Pass 0 runs on the following edge.
                    state_d = S_SORT;
                    pass_d  = '0;
                end

                S_SORT: begin
                    if (!pass_q[0]) begin
                        for (int k = 0; k < N / 2; k++) begin
                            if (mem_q[2*k] > mem_q[2*k+1]) begin
                                mem_d[2*k]   = mem_q[2*k+1];
                                mem_d[2*k+1] = mem_q[2*k];
                            end
                        end
                    end else begin
                        // Odd pass: mem[0] and mem[N-1] have no partner.
                        for (int k = 0; k < N / 2 - 1; k++) begin
                            if (mem_q[2*k+1] > mem_q[2*k+2]) begin
                                mem_d[2*k+1] = mem_q[2*k+2];
                                mem_d[2*k+2] = mem_q[2*k+1];
                            end
                        end
                    end
                    pass_d = pass_q + 1'b1;
                    // N passes of odd-even transposition sort N elements.
                    if (pass_q == LAST) begin
                        state_d   = S_OUTPUT;
                        out_cnt_d = '0;
                        started_d = 1'b1;
                    end
                end

                S_OUTPUT: begin
                    if (out_cnt_q == LAST) begin
                        state_d    = S_DONE;
                        finished_d = 1'b1;
                    end else begin
                        out_cnt_d = out_cnt_q + 1'b1;
                    end
                end

                default: ;  // S_DONE: frozen until reset
            endcase
        end
    end

    // NOTE: the array is reset on purpose, because reset must reload the
    // seed pattern. This makes it a register file, not an inferable RAM.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            pass_q     <= '0;
            out_cnt_q  <= '0;
            started_q  <= 1'b0;
            finished_q <= 1'b0;
            for (int i = 0; i < N; i++) begin
                mem_q[i] <= seed_word(i);
            end
        end else begin
            // NOTE: non-blocking assignments let every flop sample the
            // pre-edge values. The parallel compare-swap depends on that.
            state_q    <= state_d;
            pass_q     <= pass_d;
            out_cnt_q  <= out_cnt_d;
            started_q  <= started_d;
            finished_q <= finished_d;
            mem_q      <= mem_d;
        end
    end

    // out_cnt never exceeds N-1, so its low bits address the array.
    assign dout     = mem_q[out_cnt_q[IDX_W-1:0]];
    assign out_cnt  = out_cnt_q;
    assign started  = started_q;
    assign finished = finished_q;

endmodule

// File: tb/tb_hw_sorter.sv
// -----------------------------------------------------------------------------
// tb_hw_sorter
//   Self-checking bench for hw_sorter.
//   The reference model counts enabled edges since reset. From that count it
//   derives the expected phase, out_cnt, flags and dout.
//   Expected data come from the reset pattern after a plain queue sort.
// -----------------------------------------------------------------------------
module tb_hw_sorter;

    localparam int N     = 128;
    localparam int W     = 32;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             ena = 1'b0;
    logic [W-1:0]     dout;
    logic [CNT_W-1:0] out_cnt;
    logic             started;
    logic             finished;

    hw_sorter #(.N(N), .W(W), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .ena      (ena),
        .dout     (dout),
        .out_cnt  (out_cnt),
        .started  (started),
        .finished (finished)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit [31:0] pattern [N];
    bit [31:0] sorted_q [$];

    initial begin
        for (int i = 0; i < N; i++) begin
            pattern[i] = 32'(i) * 32'h9E37_79B1;
            sorted_q.push_back(pattern[i]);
        end
        sorted_q.sort();
    end

    // Count of enabled edges since the last reset, saturated past DONE.
    int en_edges;
    always @(posedge clk or negedge rst) begin
        if (!rst) en_edges <= 0;
        else if (ena && en_edges <= 2 * N) en_edges <= en_edges + 1;
    end

    // Expected behaviour by enabled-edge count e:
    //   e = 0            -> IDLE
    //   1 <= e <= N      -> SORT
    //   N+1 <= e <= 2N   -> OUTPUT, word e-N-1
    //   e > 2N           -> DONE
    bit mon_en = 1'b0;
    always @(negedge clk) begin
        if (mon_en) begin
            if (en_edges == 0) begin
                check("mon_idle_dout", dout, pattern[0]);
                check("mon_idle_cnt", 32'(out_cnt), 0);
                check("mon_idle_flags", {started, finished}, 0);
            end else if (en_edges <= N) begin
                check("mon_sort_cnt", 32'(out_cnt), 0);
                check("mon_sort_flags", {started, finished}, 0);
            end else if (en_edges <= 2 * N) begin
                check("mon_out_cnt", 32'(out_cnt), 32'(en_edges - N - 1));
                check("mon_out_flags", {started, finished}, 2'b10);
                check("mon_out_dout", dout, sorted_q[en_edges - N - 1]);
            end else begin
                check("mon_done_cnt", 32'(out_cnt), N - 1);
                check("mon_done_flags", {started, finished}, 2'b11);
                check("mon_done_dout", dout, sorted_q[N - 1]);
            end
        end
    end

    // ---------------- directed helpers ----------------
    bit [31:0] stream [$];

    // Called at a negedge with the DUT in IDLE.
    // Edge counting starts at the first ena edge, and two 10-cycle pauses are inserted.
    task automatic run_stream(input int pause_a, input int pause_b,
                              output int t_start, output int t_fin);
        int cyc;
        logic [CNT_W-1:0] last_cnt;
        bit have;
        cyc = 0;
        have = 1'b0;
        last_cnt = '0;
        t_start = -1;
        t_fin = -1;
        stream.delete();
        while (t_fin < 0 && cyc < 1000) begin
            ena = !((cyc >= pause_a && cyc < pause_a + 10) ||
                    (cyc >= pause_b && cyc < pause_b + 10));
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (started && t_start < 0) t_start = cyc;
            if (finished && t_fin < 0) t_fin = cyc;
            if (started && !finished && (!have || out_cnt != last_cnt)) begin
                stream.push_back(dout);
                last_cnt = out_cnt;
                have = 1'b1;
            end
        end
        ena = 1'b0;
    endtask

    task automatic check_stream(input string tag);
        check({tag, "_len"}, stream.size(), N);
        if (stream.size() == N) begin
            check({tag, "_first"}, stream[0], 32'h0);
            for (int i = 0; i < N; i++) begin
                check({tag, "_word"}, stream[i], sorted_q[i]);
                if (i > 0) check({tag, "_order"}, 32'(stream[i] >= stream[i-1]), 1);
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst = 1'b0;
        ena = 1'b0;
        @(negedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int ts, tf, w;

        // 1: reset state
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_dout", dout, 32'h0);
        check("rst_cnt", 32'(out_cnt), 0);
        check("rst_flags", {started, finished}, 0);
        #1;
        rst = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);

        // 2/3: continuous run, timing and order
        run_stream(-100, -100, ts, tf);
        check("t_started", ts, 129);
        check("t_finished", tf, 257);
        check_stream("run");

        // 4: pauses mid-SORT and mid-OUTPUT
        do_reset();
        run_stream(50, 200, ts, tf);
        check("pause_started", ts, 139);
        check("pause_finished", tf, 277);
        check_stream("pause");

        // Random ena with occasional aborting resets; the monitor checks each cycle.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            #1;
            if ($urandom_range(0, 799) == 0) begin
                rst = 1'b0;
                ena = 1'b0;
                @(negedge clk);
                #1;
                rst = 1'b1;
            end
            ena = ($urandom_range(0, 3) != 0);
        end

        // 5: abort during OUTPUT at out_cnt=40, then rerun
        do_reset();
        ena = 1'b1;
        w = 0;
        while (!(started && out_cnt == 8'd40) && w < 400) begin
            @(negedge clk);
            w++;
        end
        check("abort_reached", 32'(w < 400), 1);
        ena = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("abort_cnt", 32'(out_cnt), 0);
        check("abort_flags", {started, finished}, 0);
        check("abort_dout", dout, 32'h0);
        @(negedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        run_stream(-100, -100, ts, tf);
        check("abort_started", ts, 129);
        check("abort_finished", tf, 257);
        check_stream("abort");

        // 6: hold after finished
        ena = 1'b1;
        repeat (50) @(posedge clk);
        @(negedge clk);
        check("hold_cnt", 32'(out_cnt), N - 1);
        check("hold_dout", dout, sorted_q[N - 1]);
        check("hold_flags", {started, finished}, 2'b11);

        mon_en = 1'b0;
        ena = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
